// File: rtl/instr_pkg.sv
// Shared definitions for the instruction packer: field widths, format and
// error encodings, FSM states and the captured instruction-field payload.
package instr_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned FMT_W = 3;
   localparam int unsigned OPC_W = 7;
   localparam int unsigned F3_W  = 3;
   localparam int unsigned F7_W  = 7;
   localparam int unsigned REG_W = 5;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned ERR_W = 2;

   typedef enum logic [FMT_W-1:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   typedef enum logic [ERR_W-1:0] {
      ERR_NONE  = 2'b00,
      ERR_FMT   = 2'b01,
      ERR_RANGE = 2'b10
   } err_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PACK  = 2'd1,
      S_WRITE = 2'd2
   } state_e;

   typedef struct packed {
      logic [FMT_W-1:0] fmt;
      logic [OPC_W-1:0] opcode;
      logic [F3_W-1:0]  funct3;
      logic [F7_W-1:0]  funct7;
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [XLEN-1:0]  imm;
   } instr_fields_t;

   // Codes 6 and 7 are the only unassigned format values.
   function automatic logic fmt_legal(input logic [FMT_W-1:0] f);
      return (f <= FMT_J);
   endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational instruction-word assembly from captured fields.
// Ports: fields (captured payload) -> word (32-bit encoding), range_err
// (immediate not representable; only ever set when IMM_RANGE_CHECK_EN is
// defined, otherwise immediates are truncated to their fields).
module imm_pack
   import instr_pkg::*;
(
   input  instr_fields_t   fields,
   output logic [XLEN-1:0] word,
   output logic            range_err
);

   // Field placement per instruction format.
   always_comb begin
      word = '0;
      case (fields.fmt)
         FMT_R: word = {fields.funct7, fields.rs2, fields.rs1, fields.funct3, fields.rd, fields.opcode};
         FMT_I: word = {fields.imm[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
         FMT_S: word = {fields.imm[11:5], fields.rs2, fields.rs1, fields.funct3, fields.imm[4:0], fields.opcode};
         FMT_B: word = {fields.imm[12], fields.imm[10:5], fields.rs2, fields.rs1, fields.funct3,
                        fields.imm[4:1], fields.imm[11], fields.opcode};
         FMT_U: word = {fields.imm[31:12], fields.rd, fields.opcode};
         FMT_J: word = {fields.imm[20], fields.imm[10:1], fields.imm[11], fields.imm[19:12],
                        fields.rd, fields.opcode};
         default: word = '0;
      endcase
   end

`ifdef IMM_RANGE_CHECK_EN
   // A value fits an N-bit signed field when every bit above the sign bit
   // repeats it; branch and jump offsets must also be even.
   always_comb begin
      range_err = 1'b0;
      case (fields.fmt)
         FMT_I, FMT_S: range_err = (fields.imm[31:11] != {21{fields.imm[11]}});
         FMT_B:        range_err = (fields.imm[31:12] != {20{fields.imm[12]}}) || fields.imm[0];
         FMT_J:        range_err = (fields.imm[31:20] != {12{fields.imm[20]}}) || fields.imm[0];
         FMT_U:        range_err = (fields.imm[11:0] != 12'h000);
         default:      range_err = 1'b0;
      endcase
   end
`else
   assign range_err = 1'b0;
`endif

endmodule

// File: rtl/instr_packer.sv
// Instruction packer: accepts decoded instruction fields, packs them into a
// 32-bit word and writes it to sequential memory addresses.
// Ports: clk, reset (async, active-high); in_valid/in_ready field handshake;
// fmt, opcode, funct3, funct7, rd, rs1, rs2, imm fields; load_base/base_addr
// write-address preload; mem_we/mem_addr/mem_wdata/mem_ready write port;
// count (words written, saturating); err/err_code sticky error, clr_err.
// Build option: IMM_RANGE_CHECK_EN rejects immediates that do not fit.
module instr_packer
   import instr_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [FMT_W-1:0]  fmt,
   input  logic [OPC_W-1:0]  opcode,
   input  logic [F3_W-1:0]   funct3,
   input  logic [F7_W-1:0]   funct7,
   input  logic [REG_W-1:0]  rd,
   input  logic [REG_W-1:0]  rs1,
   input  logic [REG_W-1:0]  rs2,
   input  logic [XLEN-1:0]   imm,
   input  logic              load_base,
   input  logic [XLEN-1:0]   base_addr,
   output logic              mem_we,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic              mem_ready,
   output logic [CNT_W-1:0]  count,
   output logic              err,
   output logic [ERR_W-1:0]  err_code,
   input  logic              clr_err
);

   state_e          state_q, state_d;
   instr_fields_t   fields_q;
   logic [XLEN-1:0] pack_word;
   logic            range_err;
   logic            accept, launch, commit, fmt_fail, rng_fail;

   imm_pack u_imm_pack (
      .fields    (fields_q),
      .word      (pack_word),
      .range_err (range_err)
   );

   // A pending base load blocks acceptance for that cycle.
   assign in_ready = (state_q == S_IDLE) && !load_base;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state and datapath strobes.
   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      launch   = 1'b0;
      commit   = 1'b0;
      fmt_fail = 1'b0;
      rng_fail = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid && !load_base) begin
               accept  = 1'b1;
               state_d = S_PACK;
            end
         end
         S_PACK: begin
            if (!fmt_legal(fields_q.fmt)) begin
               fmt_fail = 1'b1;
               state_d  = S_IDLE;
            end else if (range_err) begin
               rng_fail = 1'b1;
               state_d  = S_IDLE;
            end else begin
               launch   = 1'b1;
               state_d  = S_WRITE;
            end
         end
         S_WRITE: begin
            if (mem_ready) begin
               commit  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Field capture, write port, address/count and sticky error registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fields_q  <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         count     <= '0;
         err       <= 1'b0;
         err_code  <= ERR_NONE;
      end else begin
         if (accept) begin
            fields_q <= '{fmt: fmt, opcode: opcode, funct3: funct3, funct7: funct7,
                          rd: rd, rs1: rs1, rs2: rs2, imm: imm};
         end
         if ((state_q == S_IDLE) && load_base) begin
            mem_addr <= base_addr;
            count    <= '0;
         end
         if (launch) begin
            mem_wdata <= pack_word;
            mem_we    <= 1'b1;
         end
         if (commit) begin
            mem_we   <= 1'b0;
            mem_addr <= mem_addr + XLEN'(4);
            if (count != {CNT_W{1'b1}}) count <= count + CNT_W'(1);
         end
         // A new error takes precedence over a same-cycle clear.
         if (fmt_fail) begin
            err      <= 1'b1;
            err_code <= ERR_FMT;
         end else if (rng_fail) begin
            err      <= 1'b1;
            err_code <= ERR_RANGE;
         end else if (clr_err) begin
            err      <= 1'b0;
            err_code <= ERR_NONE;
         end
      end
   end

endmodule

// File: tb/tb_instr_packer.sv
// Self-checking bench for instr_packer with a behavioural encoding model.
module tb_instr_packer;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready;
   logic [2:0]  fmt;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rd, rs1, rs2;
   logic [31:0] imm;
   logic        load_base;
   logic [31:0] base_addr;
   logic        mem_we, mem_ready;
   logic [31:0] mem_addr, mem_wdata;
   logic [15:0] count;
   logic        err, clr_err;
   logic [1:0]  err_code;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_addr;
   logic [15:0] exp_count;
   logic        exp_err;
   logic [1:0]  exp_code;

   always #5 clk = ~clk;

   instr_packer dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
      .load_base(load_base), .base_addr(base_addr),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
      .count(count), .err(err), .err_code(err_code), .clr_err(clr_err)
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Reference encoding built from shifted/masked field values.
   function automatic bit [31:0] ref_word(input int f, input int op, input int f3, input int f7,
                                          input int d, input int s1, input int s2, input bit [31:0] u);
      bit [31:0] o, a, b, rdv, r1, r2;
      o = 32'(op); a = 32'(f3); b = 32'(f7); rdv = 32'(d); r1 = 32'(s1); r2 = 32'(s2);
      case (f)
         0: return (b << 25) | (r2 << 20) | (r1 << 15) | (a << 12) | (rdv << 7) | o;
         1: return ((u & 32'hFFF) << 20) | (r1 << 15) | (a << 12) | (rdv << 7) | o;
         2: return (((u >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (a << 12)
                   | ((u & 32'h1F) << 7) | o;
         3: return (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (r2 << 20) | (r1 << 15)
                   | (a << 12) | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | o;
         4: return (u & 32'hFFFFF000) | (rdv << 7) | o;
         5: return (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 1) << 20)
                   | (((u >> 12) & 32'hFF) << 12) | (rdv << 7) | o;
         default: return 32'h0;
      endcase
   endfunction

   // Immediate representability from signed-integer ranges.
   function automatic bit ref_imm_ok(input int f, input bit [31:0] u);
      int s;
      s = $signed(u);
      case (f)
         1, 2: return (s >= -2048) && (s <= 2047);
         3:    return (s >= -4096) && (s <= 4094) && (u[0] == 1'b0);
         5:    return (s >= -(1 << 20)) && (s <= (1 << 20) - 2) && (u[0] == 1'b0);
         4:    return (u & 32'hFFF) == 0;
         default: return 1'b1;
      endcase
   endfunction

   // Predicts whether a transaction writes and updates the expected error state.
   task automatic model_expect(input int f, input bit [31:0] u, input bit clr_in_pack, output bit we);
      we = 1'b1;
      if (f < 0 || f > 5) begin
         we = 1'b0; exp_err = 1'b1; exp_code = 2'b01;
      end
`ifdef IMM_RANGE_CHECK_EN
      if (we && !ref_imm_ok(f, u)) begin
         we = 1'b0; exp_err = 1'b1; exp_code = 2'b10;
      end
`endif
      if (we && clr_in_pack) begin
         exp_err = 1'b0; exp_code = 2'b00;
      end
   endtask

   // Drives one instruction and observes the resulting write (no checking).
   task automatic send(input int f, input int op, input int f3, input int f7, input int d,
                       input int s1, input int s2, input bit [31:0] u, input int stall,
                       input bit clr_in_pack, output bit got_we, output bit [31:0] got_data,
                       output bit [31:0] got_addr, output int lat, output bit stable);
      @(negedge clk);
      fmt = 3'(f); opcode = 7'(op); funct3 = 3'(f3); funct7 = 7'(f7);
      rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2); imm = u; in_valid = 1'b1;
      got_we = 1'b0; got_data = '0; got_addr = '0; stable = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; lat = 1;
      if (clr_in_pack) clr_err = 1'b1;
      for (int i = 0; i < 6 && !got_we; i++) begin
         if (mem_we === 1'b1) begin
            got_we = 1'b1; got_data = mem_wdata; got_addr = mem_addr;
         end else begin
            @(negedge clk); clr_err = 1'b0; lat++;
         end
      end
      clr_err = 1'b0;
      if (got_we) begin
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (mem_we !== 1'b1 || mem_wdata !== got_data || mem_addr !== got_addr) stable = 1'b0;
         end
         mem_ready = 1'b1;
         @(negedge clk);
         mem_ready = 1'b0;
      end
   endtask

   task automatic pulse_clr();
      @(negedge clk); clr_err = 1'b1;
      @(negedge clk); clr_err = 1'b0;
      exp_err = 1'b0; exp_code = 2'b00;
   endtask

   task automatic do_load(input bit [31:0] b);
      @(negedge clk);
      load_base = 1'b1; base_addr = b; in_valid = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL load_in_ready got=%0b exp=0", in_ready); end
      @(negedge clk);
      load_base = 1'b0; in_valid = 1'b0;
      exp_addr = b; exp_count = 16'd0;
      checks++; if (mem_addr !== b) begin errors++; $display("FAIL load_addr got=%h exp=%h", mem_addr, b); end
      checks++; if (count !== 16'd0) begin errors++; $display("FAIL load_count got=%0d exp=0", count); end
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 0; fmt = 0; opcode = 0; funct3 = 0; funct7 = 0;
      rd = 0; rs1 = 0; rs2 = 0; imm = 0; load_base = 0; base_addr = 0; mem_ready = 0; clr_err = 0;
      repeat (3) @(negedge clk);
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%0b exp=0", mem_we); end
      checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
      checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata); end
      checks++; if (count !== 16'h0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (err !== 1'b0 || err_code !== 2'b00) begin errors++; $display("FAIL reset_err got=%0b/%b exp=0/00", err, err_code); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
      reset = 1'b0;
      exp_addr = 0; exp_count = 0; exp_err = 0; exp_code = 0;
   endtask

   // Known encodings; the S case stalls mem_ready for three cycles.
   task automatic test_directed();
      int          tf[5]  = '{1, 2, 3, 5, 4};
      int          top[5] = '{8'h13, 8'h23, 8'h63, 8'h6F, 8'h37};
      int          trd[5] = '{1, 0, 0, 1, 5};
      int          tr1[5] = '{0, 1, 0, 0, 0};
      int          tr2[5] = '{0, 2, 0, 0, 0};
      int          tf3[5] = '{0, 2, 0, 0, 0};
      bit [31:0]   tim[5] = '{32'd5, 32'd8, 32'hFFFFFFFC, 32'd2048, 32'h12345000};
      bit [31:0]   twd[5] = '{32'h00500093, 32'h0020A423, 32'hFE000EE3, 32'h001000EF, 32'h123452B7};
      int          tst[5] = '{0, 3, 0, 1, 0};
      bit we; bit [31:0] d, a; int lat; bit st;
      do_load(32'h100);
      for (int i = 0; i < 5; i++) begin
         send(tf[i], top[i], tf3[i], 0, trd[i], tr1[i], tr2[i], tim[i], tst[i], 1'b0, we, d, a, lat, st);
         checks++; if (we !== 1'b1) begin errors++; $display("FAIL dir%0d_we got=%0b exp=1", i, we); end
         checks++; if (d !== twd[i]) begin errors++; $display("FAIL dir%0d_word got=%h exp=%h", i, d, twd[i]); end
         checks++; if (a !== exp_addr) begin errors++; $display("FAIL dir%0d_addr got=%h exp=%h", i, a, exp_addr); end
         checks++; if (lat !== 2) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=2", i, lat); end
         if (tst[i] > 0) begin
            checks++; if (st !== 1'b1) begin errors++; $display("FAIL dir%0d_stall_stable got=%0b exp=1", i, st); end
         end
         exp_addr += 4; exp_count += 1;
         checks++; if (count !== exp_count) begin errors++; $display("FAIL dir%0d_count got=%0d exp=%0d", i, count, exp_count); end
         checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL dir%0d_we_drop got=%0b exp=0", i, mem_we); end
      end
   endtask

   task automatic test_back_to_back();
      bit [31:0] wa, wb;
      wa = ref_word(1, 8'h13, 0, 0, 2, 3, 0, 32'd100);
      wb = ref_word(0, 8'h33, 5, 7'h20, 9, 10, 11, 32'h0);
      @(negedge clk);
      fmt = 3'd1; opcode = 7'h13; funct3 = 0; funct7 = 0; rd = 2; rs1 = 3; rs2 = 0; imm = 32'd100;
      in_valid = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_pack got=%0b exp=0", in_ready); end
      fmt = 3'd0; opcode = 7'h33; funct3 = 5; funct7 = 7'h20; rd = 9; rs1 = 10; rs2 = 11; imm = 32'hDEADBEEF;
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_write got=%0b exp=0", in_ready); end
      checks++; if (mem_we !== 1'b1 || mem_wdata !== wa) begin errors++; $display("FAIL b2b_first got=%0b/%h exp=1/%h", mem_we, mem_wdata, wa); end
      checks++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL b2b_first_addr got=%h exp=%h", mem_addr, exp_addr); end
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0; exp_addr += 4; exp_count += 1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_idle got=%0b exp=1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL b2b_pack_we got=%0b exp=0", mem_we); end
      @(negedge clk);
      checks++; if (mem_we !== 1'b1 || mem_wdata !== wb) begin errors++; $display("FAIL b2b_second got=%0b/%h exp=1/%h", mem_we, mem_wdata, wb); end
      checks++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL b2b_second_addr got=%h exp=%h", mem_addr, exp_addr); end
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0; exp_addr += 4; exp_count += 1;
      checks++; if (count !== exp_count) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", count, exp_count); end
   endtask

   task automatic test_illegal_fmt();
      bit we, ewe; bit [31:0] d, a; int lat; bit st;
      model_expect(7, 32'h0, 1'b0, ewe);
      send(7, 8'h13, 0, 0, 1, 0, 0, 32'h0, 0, 1'b0, we, d, a, lat, st);
      checks++; if (we !== 1'b0) begin errors++; $display("FAIL fmt7_we got=%0b exp=0", we); end
      checks++; if (err !== exp_err || err_code !== exp_code) begin errors++; $display("FAIL fmt7_err got=%0b/%b exp=%0b/%b", err, err_code, exp_err, exp_code); end
      checks++; if (mem_addr !== exp_addr || count !== exp_count) begin errors++; $display("FAIL fmt7_nowrite got=%h/%0d exp=%h/%0d", mem_addr, count, exp_addr, exp_count); end
      pulse_clr();
      checks++; if (err !== 1'b0 || err_code !== 2'b00) begin errors++; $display("FAIL clr_err got=%0b/%b exp=0/00", err, err_code); end
      model_expect(6, 32'h0, 1'b1, ewe);
      send(6, 8'h13, 0, 0, 1, 0, 0, 32'h0, 0, 1'b1, we, d, a, lat, st);
      checks++; if (err !== exp_err || err_code !== exp_code) begin errors++; $display("FAIL err_beats_clr got=%0b/%b exp=%0b/%b", err, err_code, exp_err, exp_code); end
      pulse_clr();
   endtask

   task automatic test_imm_range();
      bit we, ewe; bit [31:0] d, a; int lat; bit st;
      bit [31:0] ew;
      model_expect(1, 32'd4096, 1'b0, ewe);
      ew = ref_word(1, 8'h13, 0, 0, 1, 0, 0, 32'd4096);
      send(1, 8'h13, 0, 0, 1, 0, 0, 32'd4096, 0, 1'b0, we, d, a, lat, st);
      checks++; if (we !== ewe) begin errors++; $display("FAIL imm4096_we got=%0b exp=%0b", we, ewe); end
      if (ewe) begin
         checks++; if (d !== ew) begin errors++; $display("FAIL imm4096_word got=%h exp=%h", d, ew); end
         exp_addr += 4; exp_count += 1;
      end
      checks++; if (err !== exp_err || err_code !== exp_code) begin errors++; $display("FAIL imm4096_err got=%0b/%b exp=%0b/%b", err, err_code, exp_err, exp_code); end
      checks++; if (count !== exp_count) begin errors++; $display("FAIL imm4096_count got=%0d exp=%0d", count, exp_count); end
      pulse_clr();
   endtask

   task automatic test_random();
      bit we, ewe; bit [31:0] d, a, u, ew; int lat; bit st;
      int f, op, f3, f7, drd, s1, s2, stall;
      for (int n = 0; n < 40; n++) begin
         f  = ($urandom_range(0, 9) == 0) ? 6 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 5));
         op = int'($urandom_range(0, 127)); f3 = int'($urandom_range(0, 7)); f7 = int'($urandom_range(0, 127));
         drd = int'($urandom_range(0, 31)); s1 = int'($urandom_range(0, 31)); s2 = int'($urandom_range(0, 31));
         case ($urandom_range(0, 3))
            0: u = 32'(int'($urandom_range(0, 4095)) - 2048);
            1: u = $urandom;
            2: u = $urandom & 32'hFFFFF000;
            default: u = 32'(int'($urandom_range(0, 2097151)) - 1048576) & 32'hFFFFFFFE;
         endcase
         stall = int'($urandom_range(0, 2));
         model_expect(f, u, 1'b0, ewe);
         ew = ref_word(f, op, f3, f7, drd, s1, s2, u);
         send(f, op, f3, f7, drd, s1, s2, u, stall, 1'b0, we, d, a, lat, st);
         checks++; if (we !== ewe) begin errors++; $display("FAIL rnd%0d_we fmt=%0d imm=%h got=%0b exp=%0b", n, f, u, we, ewe); end
         if (we && ewe) begin
            checks++; if (d !== ew) begin errors++; $display("FAIL rnd%0d_word fmt=%0d got=%h exp=%h", n, f, d, ew); end
            checks++; if (a !== exp_addr) begin errors++; $display("FAIL rnd%0d_addr got=%h exp=%h", n, a, exp_addr); end
            if (stall > 0) begin
               checks++; if (st !== 1'b1) begin errors++; $display("FAIL rnd%0d_stable got=%0b exp=1", n, st); end
            end
         end
         if (ewe) begin exp_addr += 4; exp_count += 1; end
         checks++; if (count !== exp_count) begin errors++; $display("FAIL rnd%0d_count got=%0d exp=%0d", n, count, exp_count); end
         checks++; if (err !== exp_err || err_code !== exp_code) begin errors++; $display("FAIL rnd%0d_err got=%0b/%b exp=%0b/%b", n, err, err_code, exp_err, exp_code); end
      end
      pulse_clr();
   endtask

   task automatic test_wrap();
      bit we; bit [31:0] d, a; int lat; bit st;
      do_load(32'hFFFFFFFC);
      send(0, 8'h33, 0, 0, 1, 2, 3, 32'h0, 0, 1'b0, we, d, a, lat, st);
      checks++; if (a !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_addr got=%h exp=fffffffc", a); end
      checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got=%h exp=00000000", mem_addr); end
      checks++; if (count !== 16'd1) begin errors++; $display("FAIL wrap_count got=%0d exp=1", count); end
   endtask

   task automatic test_reset_mid_write();
      @(negedge clk);
      fmt = 3'd1; opcode = 7'h13; funct3 = 0; funct7 = 0; rd = 4; rs1 = 0; rs2 = 0; imm = 32'd7;
      in_valid = 1'b1;
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk);
      checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rstw_we_before got=%0b exp=1", mem_we); end
      #1 reset = 1'b1;
      #1;
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rstw_we got=%0b exp=0", mem_we); end
      checks++; if (count !== 16'd0 || mem_addr !== 32'h0) begin errors++; $display("FAIL rstw_state got=%0d/%h exp=0/0", count, mem_addr); end
      @(negedge clk); reset = 1'b0;
      mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      mem_ready = 1'b0;
      checks++; if (count !== 16'd0 || mem_we !== 1'b0) begin errors++; $display("FAIL rstw_abandon got=%0d/%0b exp=0/0", count, mem_we); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_illegal_fmt();
      test_imm_range();
      test_random();
      test_wrap();
      test_reset_mid_write();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_packer.md
INSTR_PACKER -- requirements
Module: instr_packer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high.
REQ-003 SHALL have: in_valid  in  1 / in_ready  out  1  instruction-field handshake.
REQ-004 SHALL have: fmt  in  3  format (0 R, 1 I, 2 S, 3 B, 4 U, 5 J; 6–7 illegal).
REQ-005 SHALL have: opcode  in  7; funct3  in  3; funct7  in  7; rd, rs1, rs2  in  5 each.
REQ-006 SHALL have: imm  in  32  signed immediate value (U: full value, low 12 bits expected zero).
REQ-007 SHALL have: load_base  in  1; base_addr  in  32  write-address preload.
REQ-008 SHALL have: mem_we  out  1; mem_addr  out  32 byte address; mem_wdata  out  32; mem_ready  in  1.
REQ-009 SHALL have: count  out  16  words written; err  out  1 sticky; err_code  out  2; clr_err  in  1.

Function
REQ-010 SHALL run FSM IDLE -> PACK -> WRITE -> IDLE; in_ready = (state==IDLE) && !load_base.
REQ-011 SHALL capture all field inputs on the edge where in_valid && in_ready.
REQ-012 SHALL form the word in PACK (one cycle) and register it into mem_wdata.
REQ-013 SHALL assert mem_we from the second cycle after acceptance and hold mem_wdata/mem_addr stable until mem_ready is sampled high.
REQ-014 On the mem_we && mem_ready edge: mem_addr += 4 (mod 2^32), count += 1 (saturating at 0xFFFF), go to IDLE.
REQ-015 Field placement: R {funct7,rs2,rs1,funct3,rd,opcode}; I {imm[11:0],rs1,funct3,rd,opcode}; S {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}.
REQ-016 Field placement: B {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}; U {imm[31:12],rd,opcode}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}.
REQ-017 Illegal fmt in PACK: no write, err=1, err_code=2'b01, return to IDLE.
REQ-018 load_base in IDLE: mem_addr <= base_addr, count <= 0. In PACK/WRITE it is ignored.
REQ-019 clr_err clears err/err_code next edge; a simultaneous new error wins.
REQ-020 In_valid outside IDLE is not accepted; mem_ready outside WRITE is ignored.

Reset
REQ-021 Reset SHALL force state IDLE, mem_we=0, mem_addr=0, mem_wdata=0, count=0, err=0, err_code=0, in_ready=1.
REQ-022 Reset mid-WRITE SHALL abandon the pending word (no count increment).

Configuration
REQ-023 With IMM_RANGE_CHECK_EN defined, PACK SHALL reject any of: I/S imm outside [-2048,2047]; B outside [-4096,4094] or odd; J outside [-2^20,2^20-2] or odd; U imm[11:0]≠0.
REQ-024 A rejection SHALL cause no write, err=1, and err_code=2'b10.
REQ-025 Without IMM_RANGE_CHECK_EN, immediates SHALL be silently truncated to their fields with dropped LSBs ignored; err_code 2'b10 is never produced.

Structure
REQ-026 SHALL place the fmt encodings, err_code values, and FSM state encodings in shared package instr_pkg.
REQ-027 SHALL place the combinational field packing/range check in sub-module imm_pack (fields in -> word out, range_err out); instr_packer holds the FSM and registers.

Verification
REQ-028 base_addr=0x100 load; then I, opcode 0x13, rd=1, rs1=0, f3=0, imm=5 -> mem_wdata=0x00500093 @0x100, count=1.
REQ-029 S, opcode 0x23, rs1=1, rs2=2, f3=2, imm=8 -> 0x0020A423; hold mem_ready low 3 cycles -> word/address stable, single count increment.
REQ-030 B, opcode 0x63, all regs 0, imm=-4 -> 0xFE000EE3; J, opcode 0x6F, rd=1, imm=2048 -> 0x001000EF.
REQ-031 U, opcode 0x37, rd=5, imm=0x12345000 -> 0x123452B7; back-to-back in_valid -> in_ready low during PACK/WRITE.
REQ-032 I, imm=4096: with macro -> no mem_we, err=1, err_code=2'b10; without macro -> 0x00000093 written. fmt=7 -> err_code=2'b01 in both builds.
REQ-033 Assert reset during WRITE -> mem_we drops immediately, count=0; mem_addr=0xFFFFFFFC write -> mem_addr wraps to 0x00000000.
